stim_player: RTL and testbench
==============================

Name: stim_player

Overview:
- Synthesizable opcode-driven stimulus source for b11 and the other ITC99 benchmarks.
- Sits directly upstream of the DUT and drives its x_in, stbi and __obs pins from a loadable opcode memory.
- Opcode layout per 8-bit word: bit7 = obs, bit6 = stbi, bits5:0 = x_in.
- Adds run control, hold, looping and a cycle counter so stimulus can be replayed on FPGA or in a free-running sim without a behavioural bench.

Parameters:
AW, 10, opcode memory address width (depth = 2**AW words)
OPW, 8, opcode width; fixed at 8, bit fields above are decided

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
wr_en  in  1  opcode memory write strobe
wr_addr  in  AW  write address
wr_data  in  8  opcode to write
last_addr  in  AW  address of final opcode; latched on start
start  in  1  begin playback from address 0
stop  in  1  abort playback, return to IDLE
hold  in  1  freeze playback for this cycle
loop_en  in  1  wrap to address 0 after last_addr instead of finishing
x_in  out  6  DUT data stimulus (opcode bits 5:0)
stbi  out  1  DUT strobe stimulus (opcode bit 6)
obs  out  1  DUT observation flag (opcode bit 7)
valid  out  1  high in each cycle a new opcode is presented
pc  out  AW  address of the opcode currently presented
busy  out  1  high in PRIME and RUN
done  out  1  high in DONE
cycles  out  32  count of opcodes presented since last start

Behaviour:
- Reset is sampled only on a rising clock edge. With reset=0 at an edge, all outputs go to 0 and the state goes to IDLE. The opcode memory is not cleared.
- States are IDLE, PRIME, RUN and DONE.
- Memory reads are synchronous, with one cycle of read latency. Writes are accepted only in IDLE or DONE and are ignored in PRIME and RUN.
- When a write and a start occur in the same cycle, the write commits first. Playback uses the new data.
- IDLE/DONE -> PRIME on start:
  - last_addr and loop_en are latched.
  - pc and cycles are cleared.
  - done is cleared.
- PRIME -> RUN on the next edge. This state issues the read of address 0.
- Latency: if start is sampled at edge N, opcode k appears on outputs at edge N+2+k (holds excluded), with valid=1, pc=k and cycles=k+1.
- RUN, one opcode presented per non-held cycle:
  - If the presented pc equals the latched last_addr and loop_en=0, go to DONE at the next edge.
  - If the presented pc equals the latched last_addr and loop_en=1, the next opcode is address 0, with no bubble.
- hold=1 in RUN:
  - x_in, stbi, obs and pc keep their values.
  - valid=0 and cycles does not increment.
  - On release, the next opcode follows with no skip and no duplicate. hold has no effect in other states.
- DONE:
  - x_in, stbi, obs and pc retain the last opcode.
  - valid=0, busy=0, done=1.
  - DONE persists until start, stop or reset.
- stop (any state) -> IDLE at the next edge. x_in, stbi, obs, valid, busy and done go to 0. cycles and pc retain their values.
- Priority, highest first: reset, stop, start, hold.
- start in PRIME or RUN is ignored.
- cycles saturates at 0xFFFFFFFF.
- last_addr=0 plays exactly one opcode. With loop_en=1 that opcode repeats every cycle.
- No combinational path from any input to any output.

Test Plan:
1. Load 0x81, 0x40, 0x3F, 0xC5 at addresses 0-3, last_addr=3, start at edge N -> expected:
   - Edges N+2..N+5 give (obs,stbi,x_in) = (1,0,1), (0,1,0), (0,0,63), (1,1,5), with valid=1 and pc=0..3.
   - At N+6: done=1, valid=0, cycles=4, outputs hold (1,1,5).
2. Same program, hold high for 3 cycles after the second opcode -> valid=0 for exactly 3 cycles, then 0x3F then 0xC5. cycles=4 at done; the full sequence completes at N+9.
3. loop_en=1, last_addr=1, program 0x01, 0x02 -> x_in sequence 1, 2, 1, 2, 1 with no bubble. stop after 5 opcodes -> next edge x_in=0, valid=0, busy=0, cycles=5.
4. reset=0 mid-RUN -> all outputs 0 at that edge. A restart replays the identical sequence, showing memory is retained.
5. wr_en to address 0 with 0xFF during RUN -> ignored, and the replay still shows 0x81. Write 0xFF in the same cycle as start from IDLE -> the first opcode presented is 0xFF.
6. last_addr=0, loop_en=0 -> one valid cycle, then done=1. stop and start asserted together in DONE -> IDLE, busy=0, done=0.

Source files
------------

// File: rtl/stim_player_if.sv
// Control, program-load and stimulus-output bundle of the stimulus player.
// slave is the player side, master is whoever loads and runs it.
interface stim_player_if #(parameter int AW = 10);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] last_addr;
  logic          start;
  logic          stop;
  logic          hold;
  logic          loop_en;
  logic [5:0]    x_in;
  logic          stbi;
  logic          obs;
  logic          valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [31:0]   cycles;

  modport slave (
    input  wr_en, wr_addr, wr_data, last_addr, start, stop, hold, loop_en,
    output x_in, stbi, obs, valid, pc, busy, done, cycles
  );

  modport master (
    output wr_en, wr_addr, wr_data, last_addr, start, stop, hold, loop_en,
    input  x_in, stbi, obs, valid, pc, busy, done, cycles
  );
endinterface

// File: rtl/stim_player.sv
// Opcode-driven stimulus source: replays a loadable opcode memory onto the
// x_in/stbi/obs pins of a downstream benchmark DUT, with run control, hold,
// looping and a saturating presented-opcode counter. All outputs registered.
module stim_player #(
  parameter int AW  = 10,
  parameter int OPW = 8
) (
  input  logic       clock,
  input  logic       reset,
  stim_player_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t        state;
  logic [OPW-1:0] mem [2**AW];
  logic [AW-1:0] rd_ptr;   // address of the next opcode to present
  logic [AW-1:0] last_q;
  logic          loop_q;
  logic          fin;      // final opcode presented; leave RUN next edge

  // Program load; only while not playing. Not cleared by reset.
  always_ff @(posedge clock) begin
    if (bus.wr_en && (state == IDLE || state == DONE))
      mem[bus.wr_addr] <= bus.wr_data;
  end

  // Playback FSM. The opcode register doubles as the synchronous memory read,
  // so a write committed on the start edge is seen by the first read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      fin        <= 1'b0;
      bus.x_in   <= '0;
      bus.stbi   <= 1'b0;
      bus.obs    <= 1'b0;
      bus.valid  <= 1'b0;
      bus.pc     <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.cycles <= '0;
    end else if (bus.stop) begin
      state     <= IDLE;
      fin       <= 1'b0;
      bus.x_in  <= '0;
      bus.stbi  <= 1'b0;
      bus.obs   <= 1'b0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= PRIME;
            last_q     <= bus.last_addr;
            loop_q     <= bus.loop_en;
            rd_ptr     <= '0;
            fin        <= 1'b0;
            bus.pc     <= '0;
            bus.cycles <= '0;
            bus.done   <= 1'b0;
            bus.valid  <= 1'b0;
            bus.busy   <= 1'b1;
          end
        end
        PRIME: begin
          state <= RUN;
        end
        RUN: begin
          if (fin) begin
            state     <= DONE;
            fin       <= 1'b0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
          end else if (bus.hold) begin
            bus.valid <= 1'b0;
          end else begin
            {bus.obs, bus.stbi, bus.x_in} <= mem[rd_ptr];
            bus.pc    <= rd_ptr;
            bus.valid <= 1'b1;
            if (bus.cycles != 32'hFFFF_FFFF)
              bus.cycles <= bus.cycles + 32'd1;
            if (rd_ptr == last_q) begin
              rd_ptr <= '0;
              fin    <= !loop_q;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_player.sv
// Directed bench for stim_player: program load, playback timing, hold,
// looping, stop, mid-run reset, write gating and single-opcode programs.
module tb_stim_player;
  localparam int AW = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  stim_player_if #(.AW(AW)) bus ();

  stim_player #(.AW(AW), .OPW(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_op(input string tag, input logic [7:0] op, input logic v,
                        input logic [31:0] pcv, input logic [31:0] cyc);
    chk({tag, ".op"}, 32'({bus.obs, bus.stbi, bus.x_in}), 32'(op));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".pc"}, 32'(bus.pc), pcv);
    chk({tag, ".cycles"}, bus.cycles, cyc);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  logic [7:0] prog [4] = '{8'h81, 8'h40, 8'h3F, 8'hC5};

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.last_addr = '0;
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.loop_en = 0;

    // reset state
    tick(); tick();
    chk_op("rst", 8'h00, 1'b0, 0, 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) wr(AW'(i), prog[i]);
    bus.last_addr = 3; bus.loop_en = 0;

    // 1: basic playback, opcode k at N+2+k
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("t1.busy", 32'(bus.busy), 1);
    tick();
    chk("t1.prime_valid", 32'(bus.valid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_op($sformatf("t1.k%0d", k), prog[k], 1'b1, 32'(k), 32'(k + 1));
    end
    tick();
    chk_op("t1.done", 8'hC5, 1'b0, 3, 4);
    chk("t1.done_flag", 32'(bus.done), 1);
    chk("t1.busy_off", 32'(bus.busy), 0);
    tick();
    chk("t1.done_stays", 32'(bus.done), 1);

    // 2: hold for 3 cycles after the second opcode
    go();
    tick(); chk_op("t2.k0", 8'h81, 1, 0, 1);
    tick(); chk_op("t2.k1", 8'h40, 1, 1, 2);
    bus.hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick(); chk_op($sformatf("t2.hold%0d", h), 8'h40, 0, 1, 2);
    end
    bus.hold = 1'b0;
    tick(); chk_op("t2.k2", 8'h3F, 1, 2, 3);
    tick(); chk_op("t2.k3", 8'hC5, 1, 3, 4);
    tick(); chk("t2.done", 32'(bus.done), 1); chk("t2.cycles", bus.cycles, 4);

    // 4 + 5a: write during RUN is ignored, reset mid-run clears outputs
    go();
    tick(); chk_op("t4.k0", 8'h81, 1, 0, 1);
    bus.wr_en = 1'b1; bus.wr_addr = 0; bus.wr_data = 8'hFF;
    tick(); chk_op("t4.k1", 8'h40, 1, 1, 2);
    bus.wr_en = 1'b0;
    reset = 1'b0;
    tick();
    chk_op("t4.rst", 8'h00, 0, 0, 0);
    chk("t4.rst_busy", 32'(bus.busy), 0);
    chk("t4.rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    go();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_op($sformatf("t4.replay%0d", k), prog[k], 1'b1, 32'(k), 32'(k + 1));
    end
    tick(); chk("t4.done", 32'(bus.done), 1);

    // stop from DONE keeps pc and cycles
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk_op("stop.idle", 8'h00, 0, 3, 4);
    chk("stop.done", 32'(bus.done), 0);

    // 5b: write and start on the same edge, new data is played
    bus.wr_en = 1'b1; bus.wr_addr = 0; bus.wr_data = 8'hFF; bus.start = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    tick();
    tick(); chk_op("t5.k0", 8'hFF, 1, 0, 1);
    tick(); chk_op("t5.k1", 8'h40, 1, 1, 2);

    // start during RUN is ignored
    bus.start = 1'b1;
    tick(); chk_op("t5.k2", 8'h3F, 1, 2, 3);
    bus.start = 1'b0;
    tick(); chk_op("t5.k3", 8'hC5, 1, 3, 4);
    tick(); chk("t5.done", 32'(bus.done), 1);

    // 3: looping two-opcode program, then stop
    wr(0, 8'h01); wr(1, 8'h02);
    bus.last_addr = 1; bus.loop_en = 1;
    go();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_op($sformatf("t3.k%0d", k), (k % 2 == 0) ? 8'h01 : 8'h02, 1'b1,
             32'(k % 2), 32'(k + 1));
    end
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("t3.x_in", 32'(bus.x_in), 0);
    chk("t3.valid", 32'(bus.valid), 0);
    chk("t3.busy", 32'(bus.busy), 0);
    chk("t3.cycles", bus.cycles, 5);

    // 6: single-opcode program, then stop+start together in DONE
    bus.last_addr = 0; bus.loop_en = 0;
    go();
    tick(); chk_op("t6.k0", 8'h01, 1, 0, 1);
    tick();
    chk_op("t6.done", 8'h01, 0, 0, 1);
    chk("t6.done_flag", 32'(bus.done), 1);
    bus.stop = 1'b1; bus.start = 1'b1;
    tick();
    bus.stop = 1'b0; bus.start = 1'b0;
    chk("t6.ss_busy", 32'(bus.busy), 0);
    chk("t6.ss_done", 32'(bus.done), 0);
    chk("t6.ss_valid", 32'(bus.valid), 0);
    tick(); tick();
    chk("t6.idle_busy", 32'(bus.busy), 0);
    chk("t6.idle_valid", 32'(bus.valid), 0);

    // single opcode looping repeats every cycle
    bus.loop_en = 1;
    go();
    for (int k = 0; k < 3; k++) begin
      tick(); chk_op($sformatf("t6.loop%0d", k), 8'h01, 1, 0, 32'(k + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
